// File: rtl/jump_ctrl_if.sv
// Control bundle between the instruction sequencer and the datapath.
// The sequencer drives the strobes; the datapath side supplies run/opcode/con_ff.
interface jump_ctrl_if #(
  parameter int unsigned NREGS = 16
);
  logic             run;
  logic [4:0]       opcode;
  logic             con_ff;

  logic             pc_out, mar_in, inc_pc, z_in, zlo_out, read, mdr_in, mdr_out, ir_in;
  logic             gra, grb, rout, y_in, c_out, con_in, pc_in;
  logic [NREGS-1:0] link_in;
  logic [4:0]       ops;
  logic [3:0]       step;
  logic             busy, instr_done, illegal;

  modport master (
    input  run, opcode, con_ff,
    output pc_out, mar_in, inc_pc, z_in, zlo_out, read, mdr_in, mdr_out, ir_in,
    output gra, grb, rout, y_in, c_out, con_in, pc_in, link_in, ops, step,
    output busy, instr_done, illegal
  );

  modport slave (
    output run, opcode, con_ff,
    input  pc_out, mar_in, inc_pc, z_in, zlo_out, read, mdr_in, mdr_out, ir_in,
    input  gra, grb, rout, y_in, c_out, con_in, pc_in, link_in, ops, step,
    input  busy, instr_done, illegal
  );
endinterface

// File: rtl/jump_ctrl.sv
// Control-step sequencer for fetch plus jr/jal/branch execution (T0..T6).
// Strobes are decoded from the registered step, so reset clears them immediately.
module jump_ctrl #(
  parameter int unsigned NREGS    = 16,
  parameter int unsigned LINK_REG = 15,
  parameter int unsigned READ_LAT = 1,
  parameter logic [4:0]  OP_JR    = 5'b10100,
  parameter logic [4:0]  OP_JAL   = 5'b10011,
  parameter logic [4:0]  OP_BR    = 5'b10010,
  parameter logic [4:0]  ADD_OP   = 5'd3
) (
  input logic         clock,
  input logic         clear,
  jump_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StT0   = 4'd1,
    StT1   = 4'd2,
    StT2   = 4'd3,
    StT3   = 4'd4,
    StT4   = 4'd5,
    StT5   = 4'd6,
    StT6   = 4'd7
  } state_e;

  localparam logic [3:0]       CntInit  = 4'(READ_LAT - 1);
  localparam logic [NREGS-1:0] LinkMask = {{(NREGS-1){1'b0}}, 1'b1} << LINK_REG;

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [4:0] op_q;

  logic   is_jr, is_jal, is_br;
  state_e after_last;

  always_comb begin
    is_jr      = (bus.opcode == OP_JR);
    is_jal     = (bus.opcode == OP_JAL);
    is_br      = (bus.opcode == OP_BR);
    after_last = bus.run ? StT0 : StIdle;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      op_q    <= 5'd0;
    end else begin
      case (state_q)
        StIdle: if (bus.run) state_q <= StT0;
        StT0: begin
          state_q <= StT1;
          cnt_q   <= CntInit;
        end
        StT1: begin
          if (cnt_q == 4'd0) state_q <= StT2;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        StT2: state_q <= StT3;
        StT3: begin
          // Latch the opcode so T4..T6 are immune to IR changes.
          op_q    <= bus.opcode;
          state_q <= (is_jal || is_br) ? StT4 : after_last;
        end
        StT4:    state_q <= (op_q == OP_JAL) ? after_last : StT5;
        StT5:    state_q <= StT6;
        StT6:    state_q <= after_last;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.pc_out     = 1'b0;
    bus.mar_in     = 1'b0;
    bus.inc_pc     = 1'b0;
    bus.z_in       = 1'b0;
    bus.zlo_out    = 1'b0;
    bus.read       = 1'b0;
    bus.mdr_in     = 1'b0;
    bus.mdr_out    = 1'b0;
    bus.ir_in      = 1'b0;
    bus.gra        = 1'b0;
    bus.grb        = 1'b0;
    bus.rout       = 1'b0;
    bus.y_in       = 1'b0;
    bus.c_out      = 1'b0;
    bus.con_in     = 1'b0;
    bus.pc_in      = 1'b0;
    bus.link_in    = '0;
    bus.ops        = 5'd0;
    bus.illegal    = 1'b0;
    bus.instr_done = 1'b0;
    bus.step       = state_q;
    bus.busy       = (state_q != StIdle);
    case (state_q)
      StT0: begin
        bus.pc_out = 1'b1;
        bus.mar_in = 1'b1;
        bus.inc_pc = 1'b1;
        bus.z_in   = 1'b1;
      end
      StT1: begin
        bus.zlo_out = 1'b1;
        bus.read    = 1'b1;
        bus.mdr_in  = 1'b1;
      end
      StT2: begin
        bus.mdr_out = 1'b1;
        bus.ir_in   = 1'b1;
      end
      StT3: begin
        if (is_jr) begin
          bus.gra        = 1'b1;
          bus.rout       = 1'b1;
          bus.pc_in      = 1'b1;
          bus.instr_done = 1'b1;
        end else if (is_jal) begin
          bus.pc_out  = 1'b1;
          bus.link_in = LinkMask;
        end else if (is_br) begin
          bus.gra    = 1'b1;
          bus.rout   = 1'b1;
          bus.con_in = 1'b1;
        end else begin
          bus.illegal    = 1'b1;
          bus.instr_done = 1'b1;
        end
      end
      StT4: begin
        bus.rout = 1'b1;
        if (op_q == OP_JAL) begin
          bus.gra        = 1'b1;
          bus.pc_in      = 1'b1;
          bus.instr_done = 1'b1;
        end else begin
          bus.grb  = 1'b1;
          bus.y_in = 1'b1;
        end
      end
      StT5: begin
        bus.c_out = 1'b1;
        bus.ops   = ADD_OP;
        bus.z_in  = 1'b1;
      end
      StT6: begin
        bus.zlo_out    = 1'b1;
        bus.pc_in      = bus.con_ff;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_jump_ctrl.sv
// Bench for jump_ctrl: two instances (READ_LAT=3/LINK_REG=15 and READ_LAT=1/LINK_REG=6)
// checked each cycle against an instruction-position model, plus directed literal checks.
module tb_jump_ctrl;

  localparam logic [4:0] OP_JR  = 5'b10100;
  localparam logic [4:0] OP_JAL = 5'b10011;
  localparam logic [4:0] OP_BR  = 5'b10010;
  localparam int LA = 3, LRA = 15, LB = 1, LRB = 6;

  typedef struct packed {
    logic pc_out, mar_in, inc_pc, z_in, zlo_out, read, mdr_in, mdr_out, ir_in;
    logic gra, grb, rout, y_in, c_out, con_in, pc_in;
    logic [15:0] link_in;
    logic [4:0]  ops;
    logic [3:0]  step;
    logic busy, instr_done, illegal;
  } outs_t;

  // Model state: active flag, position within the instruction, latched opcode.
  typedef struct packed {
    bit         act;
    int         k;
    logic [4:0] lat;
  } mst_t;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       run_a = 1'b0, run_b = 1'b0, con_ff = 1'b0;
  logic [4:0] opcode = 5'd0;

  int n_chk = 0, n_fail = 0;

  jump_ctrl_if #(.NREGS(16)) bus_a ();
  jump_ctrl_if #(.NREGS(16)) bus_b ();

  assign bus_a.run = run_a;
  assign bus_a.opcode = opcode;
  assign bus_a.con_ff = con_ff;
  assign bus_b.run = run_b;
  assign bus_b.opcode = opcode;
  assign bus_b.con_ff = con_ff;

  jump_ctrl #(.READ_LAT(LA), .LINK_REG(LRA)) dut_a (.clock(clock), .clear(clear), .bus(bus_a));
  jump_ctrl #(.READ_LAT(LB), .LINK_REG(LRB)) dut_b (.clock(clock), .clear(clear), .bus(bus_b));

  outs_t out_a, out_b;
  assign out_a = {bus_a.pc_out, bus_a.mar_in, bus_a.inc_pc, bus_a.z_in, bus_a.zlo_out,
                  bus_a.read, bus_a.mdr_in, bus_a.mdr_out, bus_a.ir_in, bus_a.gra, bus_a.grb,
                  bus_a.rout, bus_a.y_in, bus_a.c_out, bus_a.con_in, bus_a.pc_in,
                  bus_a.link_in, bus_a.ops, bus_a.step, bus_a.busy, bus_a.instr_done,
                  bus_a.illegal};
  assign out_b = {bus_b.pc_out, bus_b.mar_in, bus_b.inc_pc, bus_b.z_in, bus_b.zlo_out,
                  bus_b.read, bus_b.mdr_in, bus_b.mdr_out, bus_b.ir_in, bus_b.gra, bus_b.grb,
                  bus_b.rout, bus_b.y_in, bus_b.c_out, bus_b.con_in, bus_b.pc_in,
                  bus_b.link_in, bus_b.ops, bus_b.step, bus_b.busy, bus_b.instr_done,
                  bus_b.illegal};

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction length in cycles from T0 to the final step inclusive.
  function automatic int ilen(input logic [4:0] op, input int lat);
    if (op == OP_JAL) return lat + 4;
    if (op == OP_BR)  return lat + 6;
    return lat + 3;
  endfunction

  function automatic mst_t next_m(input mst_t m, input int lat, input logic run,
                                  input logic [4:0] opc);
    mst_t n = m;
    logic [4:0] op;
    if (!m.act) begin
      n.act = run;
      n.k   = 0;
      return n;
    end
    op = (m.k == lat + 2) ? opc : m.lat;
    if (m.k == lat + 2) n.lat = opc;
    if (m.k == ilen(op, lat) - 1) begin
      n.act = run;
      n.k   = 0;
    end else begin
      n.k = m.k + 1;
    end
    return n;
  endfunction

  function automatic outs_t exp_out(input mst_t m, input int lat, input int lr,
                                    input logic [4:0] opc, input logic con);
    outs_t o = '0;
    logic [4:0] op;
    int e;
    if (!m.act) return o;
    o.busy = 1'b1;
    if (m.k == 0) begin
      o.step = 4'd1; o.pc_out = 1'b1; o.mar_in = 1'b1; o.inc_pc = 1'b1; o.z_in = 1'b1;
    end else if (m.k <= lat) begin
      o.step = 4'd2; o.zlo_out = 1'b1; o.read = 1'b1; o.mdr_in = 1'b1;
    end else if (m.k == lat + 1) begin
      o.step = 4'd3; o.mdr_out = 1'b1; o.ir_in = 1'b1;
    end else begin
      e = m.k - (lat + 2);
      op = (e == 0) ? opc : m.lat;
      o.step = 4'(4 + e);
      o.instr_done = (m.k == ilen(op, lat) - 1);
      if (op == OP_JR) begin
        o.gra = 1'b1; o.rout = 1'b1; o.pc_in = 1'b1;
      end else if (op == OP_JAL) begin
        if (e == 0) begin
          o.pc_out = 1'b1; o.link_in = 16'(1) << lr;
        end else begin
          o.gra = 1'b1; o.rout = 1'b1; o.pc_in = 1'b1;
        end
      end else if (op == OP_BR) begin
        case (e)
          0:       begin o.gra = 1'b1; o.rout = 1'b1; o.con_in = 1'b1; end
          1:       begin o.grb = 1'b1; o.rout = 1'b1; o.y_in = 1'b1; end
          2:       begin o.c_out = 1'b1; o.ops = 5'd3; o.z_in = 1'b1; end
          default: begin o.zlo_out = 1'b1; o.pc_in = con; end
        endcase
      end else begin
        o.illegal = 1'b1;
      end
    end
    return o;
  endfunction

  mst_t ma, mb;
  always @(posedge clock or negedge clear)
    if (!clear) ma <= '0;
    else        ma <= next_m(ma, LA, run_a, opcode);
  always @(posedge clock or negedge clear)
    if (!clear) mb <= '0;
    else        mb <= next_m(mb, LB, run_b, opcode);

  // Per-cycle comparison against the model, well clear of both clock edges.
  always @(negedge clock) begin
    #3;
    chk("model_a", 64'(out_a), 64'(exp_out(ma, LA, LRA, opcode, con_ff)));
    chk("model_b", 64'(out_b), 64'(exp_out(mb, LB, LRB, opcode, con_ff)));
    chk("excl_a", 64'((out_a.pc_in & out_a.inc_pc) | (out_a.pc_in & (|out_a.link_in))), 64'd0);
    chk("excl_b", 64'((out_b.pc_in & out_b.inc_pc) | (out_b.pc_in & (|out_b.link_in))), 64'd0);
  end

  outs_t cap[16];
  int    cyc, t1n, done_n, ill_n;
  logic [3:0] next_step;

  task automatic set_run(input bit sel, input logic v);
    if (sel) run_a = v;
    else     run_b = v;
  endtask

  task automatic wait_idle(input bit sel);
    outs_t v;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      #2;
      v = sel ? out_a : out_b;
      if (!v.busy) break;
    end
    v = sel ? out_a : out_b;
    chk("idle_timeout", 64'(v.busy), 64'd0);
  endtask

  // Runs one instruction from IDLE and captures per-step outputs.
  task automatic exec(input bit sel, input logic [4:0] op, input logic con, input bit keep);
    outs_t v;
    cyc = 0; t1n = 0; done_n = 0; ill_n = 0; next_step = 4'hf;
    for (int i = 0; i < 16; i++) cap[i] = '0;
    @(negedge clock);
    set_run(sel, 1'b1);
    opcode = op;
    con_ff = con;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      v = sel ? out_a : out_b;
      if (!keep) set_run(sel, 1'b0);
      if (v.step == 4'd5) opcode = ~op;
      #2;
      v = sel ? out_a : out_b;
      cyc++;
      if (v.step == 4'd2) t1n++;
      cap[v.step] = v;
      done_n += 32'(v.instr_done);
      ill_n  += 32'(v.illegal);
      if (v.instr_done) break;
    end
    @(negedge clock);
    #2;
    v = sel ? out_a : out_b;
    next_step = v.step;
    set_run(sel, 1'b0);
    wait_idle(sel);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held: outputs stay zero regardless of run/opcode.
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      run_a  = 1'($urandom);
      run_b  = 1'($urandom);
      opcode = 5'($urandom);
      #2;
      chk("reset_zero_a", 64'(out_a), 64'd0);
      chk("reset_zero_b", 64'(out_b), 64'd0);
    end
    @(negedge clock);
    clear = 1'b1; run_a = 1'b1; run_b = 1'b0;
    @(negedge clock);
    #2;
    chk("release_step", 64'(out_a.step), 64'd1);
    run_a = 1'b0;
    wait_idle(1'b1);

    // jr, READ_LAT=1, back-to-back.
    exec(1'b0, OP_JR, 1'b0, 1'b1);
    chk("jr_cycles", 64'(cyc), 64'd4);
    chk("jr_t3_strobes", 64'({cap[4].gra, cap[4].rout, cap[4].pc_in}), 64'd7);
    chk("jr_done_count", 64'(done_n), 64'd1);
    chk("jr_done_in_t3", 64'(cap[4].instr_done), 64'd1);
    chk("jr_next_step", 64'(next_step), 64'd1);

    // jal, LINK_REG=6, READ_LAT=1.
    exec(1'b0, OP_JAL, 1'b0, 1'b0);
    chk("jal_cycles", 64'(cyc), 64'd5);
    chk("jal_link", 64'(cap[4].link_in), 64'h0040);
    chk("jal_t3_pc_out", 64'(cap[4].pc_out), 64'd1);
    chk("jal_t3_pc_in", 64'(cap[4].pc_in), 64'd0);
    chk("jal_t4_pc_in", 64'(cap[5].pc_in), 64'd1);
    chk("jal_next_idle", 64'(next_step), 64'd0);

    // Branch taken and not taken, READ_LAT=3.
    exec(1'b1, OP_BR, 1'b1, 1'b0);
    chk("br1_cycles", 64'(cyc), 64'd9);
    chk("br1_t1_hold", 64'(t1n), 64'd3);
    chk("br1_t5_ops", 64'(cap[6].ops), 64'd3);
    chk("br1_t6_pc_in", 64'(cap[7].pc_in), 64'd1);
    chk("br1_done", 64'(done_n), 64'd1);
    exec(1'b1, OP_BR, 1'b0, 1'b0);
    chk("br0_cycles", 64'(cyc), 64'd9);
    chk("br0_t6_pc_in", 64'(cap[7].pc_in), 64'd0);
    chk("br0_t6_zlo", 64'(cap[7].zlo_out), 64'd1);
    chk("br0_done", 64'(done_n), 64'd1);

    // Illegal opcode on the READ_LAT=3 instance.
    exec(1'b1, 5'b00000, 1'b0, 1'b1);
    chk("ill_pulses", 64'(ill_n), 64'd1);
    chk("ill_in_t3", 64'(cap[4].illegal), 64'd1);
    chk("ill_strobes", 64'({cap[4].gra, cap[4].grb, cap[4].rout, cap[4].y_in, cap[4].c_out,
                            cap[4].con_in, cap[4].pc_in, cap[4].pc_out, cap[4].link_in}), 64'd0);
    chk("ill_cycles", 64'(cyc), 64'd6);
    chk("ill_next_step", 64'(next_step), 64'd1);

    // Asynchronous reset in the second T1 cycle.
    @(negedge clock);
    run_a = 1'b1; opcode = OP_BR;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #2;
      if (out_a.step == 4'd2) break;
    end
    chk("t1_reached", 64'(out_a.step), 64'd2);
    @(negedge clock);
    #1 clear = 1'b0;
    #1;
    chk("rst_t1_zero", 64'(out_a), 64'd0);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    #2;
    chk("rst_restart_t0", 64'(out_a.step), 64'd1);
    @(negedge clock);
    #2;
    chk("rst_restart_t1", 64'(out_a.step), 64'd2);
    run_a = 1'b0;
    wait_idle(1'b1);

    // Randomized traffic, including occasional mid-cycle resets.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      run_a  = ($urandom_range(0, 7) != 0);
      run_b  = ($urandom_range(0, 7) != 0);
      con_ff = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       opcode = OP_JR;
        1:       opcode = OP_JAL;
        2:       opcode = OP_BR;
        default: opcode = 5'($urandom);
      endcase
      clear = 1'b1;
      if ($urandom_range(0, 299) == 0) #1 clear = 1'b0;
    end
    @(negedge clock);
    clear = 1'b1; run_a = 1'b0; run_b = 1'b0;
    wait_idle(1'b1);
    wait_idle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
